// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan driver
package seg7_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes g..a for nibble values 0..15.
    // Entries 10..15 are only used when hex digits are compiled in.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Extract BCD digit k from a packed word (digit 0 in the low nibble)
    function automatic logic [3:0] digit_at(input logic [31:0] word, input int k);
        logic [31:0] shifted;
        shifted = word >> (4 * k);
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-low segments; SEG7_HEX_DIGITS_EN enables A..F glyphs
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    // Table lookup; codes above 9 are blank unless hex glyphs are built in
    always_comb begin
        seg_n = SEG_BLANK;
`ifdef SEG7_HEX_DIGITS_EN
        seg_n = SEG_CODE[digit];
`else
        if (digit <= 4'd9) begin
            seg_n = SEG_CODE[digit];
        end
`endif
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment scan driver (hex glyphs via SEG7_HEX_DIGITS_EN)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_reg_q, disp_reg_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                    adv;
    logic [3:0]              sel_digit;
    logic [6:0]              dec_seg_n;
    logic                    lz_zero;
    logic                    lz_blank;

    // Prescaler, digit index and display latch next-state
    always_comb begin
        adv        = (pre_cnt_q == PRE_MAX);
        pre_cnt_d  = adv ? '0 : pre_cnt_q + PRE_W'(1);
        idx_d      = idx_q;
        if (adv) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
        // Loads are never gated by the scan position
        disp_reg_d = load ? digits_in : disp_reg_q;
    end

    // Select the digit being scanned and check whether it and all above are zero
    always_comb begin
        sel_digit = digit_at(32'(disp_reg_q), int'(idx_q));
        lz_zero   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_q) && digit_at(32'(disp_reg_q), k) != 4'd0) begin
                lz_zero = 1'b0;
            end
        end
        // The rightmost digit always shows, so a zero value reads "0"
        lz_blank = blank_lz && (idx_q != '0) && lz_zero;
    end

    seg7_decode u_decode (
        .digit (sel_digit),
        .seg_n (dec_seg_n)
    );

    // Registered pin drive; the advance cycle is dark to stop ghosting between digits
    always_comb begin
        seg_n_d = SEG_BLANK;
        an_n_d  = '1;
        if (!adv) begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d = lz_blank ? SEG_BLANK : dec_seg_n;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            idx_q      <= '0;
            disp_reg_q <= '0;
            seg_n_q    <= SEG_BLANK;
            an_n_q     <= '1;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            idx_q      <= idx_d;
            disp_reg_q <= disp_reg_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
        end
    end

    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (honours SEG7_HEX_DIGITS_EN)
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg_n;
    logic [N-1:0]  an_n;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: clean edges since last reset, and the latched word
    int          m_n = 0;
    logic [15:0] m_disp = '0;

    seg7_scan_driver #(.NUM_DIGITS(N), .DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
`ifdef SEG7_HEX_DIGITS_EN
            10: return 7'h08; 11: return 7'h03; 12: return 7'h46;
            13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    // One clock: drive inputs, predict pins after the edge, check #1 later
    task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic blz);
        int          pre;
        int          idx;
        logic [6:0]  exp_seg;
        logic [N-1:0] exp_an;
        rst = r; load = ld; digits_in = d; blank_lz = blz;
        pre = m_n % DIV;
        idx = (m_n / DIV) % N;
        exp_seg = 7'h7F;
        exp_an  = '1;
        if (!r && pre != DIV - 1) begin
            exp_an = ~(N'(1) << idx);
            if (blz && idx > 0 && (m_disp >> (4 * idx)) == 16'd0)
                exp_seg = 7'h7F;
            else
                exp_seg = ref_glyph(int'((m_disp >> (4 * idx)) & 16'hF));
        end
        @(posedge clk);
        #1;
        check_eq("an_n", 32'(an_n), 32'(exp_an));
        check_eq("seg_n", 32'(seg_n), 32'(exp_seg));
        if (r) begin
            m_n = 0;
            m_disp = '0;
        end else begin
            if (ld) m_disp = d;
            m_n++;
        end
    endtask

    task automatic idle(input int cycles, input logic blz);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, blz);
    endtask

    initial begin
        // Reset held for three edges
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Plain scan of 1234 over two frames
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(2 * N * DIV, 1'b0);

        // Leading-zero blanking
        step(1'b0, 1'b1, 16'h0070, 1'b1);
        idle(N * DIV + 2, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(N * DIV + 2, 1'b1);

        // Hex codes
        step(1'b0, 1'b1, 16'h00AF, 1'b0);
        idle(N * DIV + 2, 1'b0);

        // Load landing exactly on the dead cycle
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < DIV && (m_n % DIV) != DIV - 1; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        idle(N * DIV + 2, 1'b0);

        // Reset pulsed while digit 2 is being shown
        for (int i = 0; i < 2 * N * DIV && !(((m_n / DIV) % N) == 2 && (m_n % DIV) == 1); i++)
            step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h9081, 1'b0);
        idle(N * DIV + 2, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            logic        r;
            logic        ld;
            d  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 4));
            r  = ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 5) == 0);
            step(r, ld, d, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
